rc4_ctrl_fsm: RTL and testbench

Sequencing controller for the RC4 datapath. It takes a single start request and drives the datapath's active-high control strobes through the phases in order: clock-divider reset, S-array load, K-array load, KSA swap loop, PRGA keystream generation, and 32-bit result readout. It terminates each phase on the datapath's `eqz3`/`eqz4`/`eqz5` flags and reports `busy`/`done` to the host side of the microprocessor.

---
 rtl/rc4_pkg.sv | 100 ++++++++++
 rtl/rc4_step_gen.sv | 30 +++
 rtl/rc4_ctrl_fsm.sv | 154 +++++++++++++++
 tb/tb_rc4_ctrl_fsm.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 sequencing controller: state encoding, the
// datapath control-strobe bundle and the datapath loop constants.
package rc4_pkg;

  localparam int         RC4_S_PAIRS  = 8;
  localparam int         RC4_N        = 16;
  localparam logic [4:0] RC4_PRGA_END = 5'b10101;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CLR      = 4'd1,
    ST_LOAD_S   = 4'd2,
    ST_LOAD_K   = 4'd3,
    ST_KSA      = 4'd4,
    ST_PRGA_CLR = 4'd5,
    ST_PRGA     = 4'd6,
    ST_READ     = 4'd7,
    ST_DONE     = 4'd8
  } rc4_state_e;

  typedef struct packed {
    logic clk_rst;
    logic reset1;
    logic reset2;
    logic reset3;
    logic reset4;
    logic reset_reg;
    logic reset_counter_final;
    logic en_s;
    logic en_k;
    logic enc;
    logic wr_1;
    logic rd_1;
  } rc4_ctrl_t;

  localparam rc4_ctrl_t CTRL_IDLE = '{
    clk_rst:             1'b1,
    reset1:              1'b1,
    reset2:              1'b1,
    reset3:              1'b1,
    reset4:              1'b1,
    reset_reg:           1'b1,
    reset_counter_final: 1'b1,
    en_s:                1'b0,
    en_k:                1'b0,
    enc:                 1'b0,
    wr_1:                1'b0,
    rd_1:                1'b0
  };

  // Steady-state strobe vector for each state; entry pulses are added by the FSM.
  function automatic rc4_ctrl_t ctrl_for_state(input rc4_state_e st);
    rc4_ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      ST_IDLE, ST_CLR: c = CTRL_IDLE;
      ST_LOAD_S: begin
        c.clk_rst = 1'b0;
        c.reset1  = 1'b0;
        c.reset2  = 1'b0;
        c.en_s    = 1'b1;
      end
      ST_LOAD_K: begin
        c.clk_rst = 1'b0;
        c.reset1  = 1'b0;
        c.reset2  = 1'b0;
        c.en_k    = 1'b1;
      end
      ST_KSA: begin
        c.clk_rst = 1'b0;
        c.reset1  = 1'b0;
        c.reset2  = 1'b0;
        c.reset3  = 1'b0;
      end
      ST_PRGA_CLR: begin
        c.clk_rst = 1'b0;
        c.reset2  = 1'b0;
        c.reset3  = 1'b0;
        c.reset4  = 1'b0;
      end
      ST_PRGA: begin
        c      = '0;
        c.enc  = 1'b1;
        c.wr_1 = 1'b1;
      end
      ST_READ, ST_DONE: begin
        c      = '0;
        c.rd_1 = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Number of keystream steps before the datapath raises eqz5.
  function automatic int prga_steps();
    return int'(RC4_PRGA_END);
  endfunction

endpackage

// File: rtl/rc4_step_gen.sv
// Datapath step strobe: one stp pulse every STEP_DIV clk cycles while the
// sequencer is running; held in its start phase while clr is high.
module rc4_step_gen #(
  parameter int STEP_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic stp
);

  localparam int            CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(STEP_DIV - 1);

  logic [CW-1:0] tmr_q;

  // Down-counter: a loaded value of STEP_DIV-1 corresponds to phase 0 of the step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q <= LOAD;
    end else if (clr || tmr_q == '0) begin
      tmr_q <= LOAD;
    end else begin
      tmr_q <= tmr_q - CW'(1);
    end
  end

  assign stp = !clr && (tmr_q == '0);

endmodule

// File: rtl/rc4_ctrl_fsm.sv
// RC4 datapath sequencer: walks clear, S/K load, KSA, PRGA and readout phases,
// ending each on the datapath eqz flags sampled at the step strobe.
//
// state       | meaning
// ST_IDLE     | all datapath clears asserted, waiting for start
// ST_CLR      | two-cycle global clear
// ST_LOAD_S   | S array load, ends on eqz3
// ST_LOAD_K   | K array load, ends on eqz4
// ST_KSA      | key-scheduling swap loop, ends on eqz4
// ST_PRGA_CLR | one-cycle clear of i/result registers before keystream
// ST_PRGA     | keystream generation, ends on eqz5
// ST_READ     | walk readout addresses 0..READ_WORDS-1
// ST_DONE     | one-cycle completion, result held stable
module rc4_ctrl_fsm
  import rc4_pkg::*;
#(
  parameter int STEP_DIV   = 2,
  parameter int READ_WORDS = RC4_S_PAIRS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       eqz3,
  input  logic       eqz4,
  input  logic       eqz5,
  output logic       clk_rst,
  output logic       reset1,
  output logic       reset2,
  output logic       reset3,
  output logic       reset4,
  output logic       reset_reg,
  output logic       reset_counter_final,
  output logic       en_s,
  output logic       en_k,
  output logic       enc,
  output logic       wr_1,
  output logic       rd_1,
  output logic [3:0] add_to_read,
  output logic       busy,
  output logic       done,
  output logic [3:0] state_o
);

  localparam logic [3:0] READ_LAST =
    4'((READ_WORDS > RC4_N) ? RC4_N - 1 : READ_WORDS - 1);

  rc4_state_e state_q, state_d;
  logic       clr_hold_q, clr_hold_d;
  rc4_ctrl_t  ctrl_q, ctrl_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] add_q, add_d;
  logic       r1_pulse;
  logic       stp;
  logic       step_clr;

  assign step_clr = (state_q == ST_IDLE) || (state_q == ST_CLR);

  rc4_step_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (step_clr),
    .stp   (stp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      clr_hold_q <= 1'b0;
      ctrl_q     <= CTRL_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      add_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_hold_q <= clr_hold_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      add_q      <= add_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_hold_d = 1'b0;
    r1_pulse   = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CLR;
      ST_CLR: begin
        if (clr_hold_q) state_d = ST_LOAD_S;
        else            clr_hold_d = 1'b1;
      end
      ST_LOAD_S: begin
        if (stp && eqz3) begin
          state_d  = ST_LOAD_K;
          r1_pulse = 1'b1;
        end
      end
      ST_LOAD_K: begin
        if (stp && eqz4) begin
          state_d  = ST_KSA;
          r1_pulse = 1'b1;
        end
      end
      ST_KSA:      if (stp && eqz4) state_d = ST_PRGA_CLR;
      ST_PRGA_CLR: state_d = ST_PRGA;
      ST_PRGA:     if (stp && eqz5) state_d = ST_READ;
      ST_READ:     if (stp && add_q == READ_LAST) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      clr_hold_d = 1'b0;
      r1_pulse   = 1'b0;
    end

    // Registered outputs are decoded from the state being entered.
    ctrl_d        = ctrl_for_state(state_d);
    ctrl_d.reset1 = ctrl_d.reset1 | r1_pulse;
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d        = (state_d == ST_DONE);

    add_d = '0;
    if (state_d == ST_READ && state_q == ST_READ) begin
      add_d = stp ? add_q + 4'd1 : add_q;
    end else if (state_d == ST_DONE) begin
      add_d = add_q;
    end
  end

  assign clk_rst             = ctrl_q.clk_rst;
  assign reset1              = ctrl_q.reset1;
  assign reset2              = ctrl_q.reset2;
  assign reset3              = ctrl_q.reset3;
  assign reset4              = ctrl_q.reset4;
  assign reset_reg           = ctrl_q.reset_reg;
  assign reset_counter_final = ctrl_q.reset_counter_final;
  assign en_s                = ctrl_q.en_s;
  assign en_k                = ctrl_q.en_k;
  assign enc                 = ctrl_q.enc;
  assign wr_1                = ctrl_q.wr_1;
  assign rd_1                = ctrl_q.rd_1;
  assign add_to_read         = add_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_rc4_ctrl_fsm.sv
// Self-checking bench for rc4_ctrl_fsm: phase-level reference model, an IDLE
// boundary vector table, directed full runs and a randomized soak.
module tb_rc4_ctrl_fsm;

  localparam int SD = 2;
  localparam int RW = 8;

  localparam int S_IDLE  = 0, S_CLR  = 1, S_LOADS = 2, S_LOADK = 3, S_KSA = 4;
  localparam int S_PCLR  = 5, S_PRGA = 6, S_READ  = 7, S_DONE  = 8;

  logic       clk, reset, start, abort, eqz3, eqz4, eqz5;
  logic       clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final;
  logic       en_s, en_k, enc, wr_1, rd_1, busy, done;
  logic [3:0] add_to_read, state_o;

  int n_tests = 0;
  int n_fail  = 0;

  rc4_ctrl_fsm #(.STEP_DIV(SD), .READ_WORDS(RW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .abort               (abort),
    .eqz3                (eqz3),
    .eqz4                (eqz4),
    .eqz5                (eqz5),
    .clk_rst             (clk_rst),
    .reset1              (reset1),
    .reset2              (reset2),
    .reset3              (reset3),
    .reset4              (reset4),
    .reset_reg           (reset_reg),
    .reset_counter_final (reset_counter_final),
    .en_s                (en_s),
    .en_k                (en_k),
    .enc                 (enc),
    .wr_1                (wr_1),
    .rd_1                (rd_1),
    .add_to_read         (add_to_read),
    .busy                (busy),
    .done                (done),
    .state_o             (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {clk_rst, reset1..4, reset_reg, reset_counter_final, en_s, en_k, enc, wr_1, rd_1, busy, done}
  logic [13:0] exp_tab [9];
  int          exp_len [9];

  typedef struct {
    bit start;
    bit abort;
    int exp_state;
    bit exp_busy;
  } idle_vec_t;
  idle_vec_t iv [9];

  // Reference model: phase, CLR cycle count, cycles since the step counter was released,
  // steps seen in this phase, readout address and pending reset1 entry pulse.
  int m_state, m_clr, m_cnt, m_pstp, m_addr;
  bit m_pulse;

  function automatic bit m_stp();
    return !(m_state == S_IDLE || m_state == S_CLR) && ((m_cnt % SD) == SD - 1);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_clr = 0; m_cnt = 0; m_pstp = 0; m_addr = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    bit s;
    int nxt;
    bit pulse;
    s = m_stp();
    nxt = m_state;
    pulse = 0;
    case (m_state)
      S_IDLE:  if (start) nxt = S_CLR;
      S_CLR:   if (m_clr == 1) nxt = S_LOADS;
      S_LOADS: if (s && eqz3) begin nxt = S_LOADK; pulse = 1; end
      S_LOADK: if (s && eqz4) begin nxt = S_KSA; pulse = 1; end
      S_KSA:   if (s && eqz4) nxt = S_PCLR;
      S_PCLR:  nxt = S_PRGA;
      S_PRGA:  if (s && eqz5) nxt = S_READ;
      S_READ:  if (s && m_addr == RW - 1) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
    if (abort) begin nxt = S_IDLE; pulse = 0; end
    m_clr = (m_state == S_CLR && nxt == S_CLR) ? m_clr + 1 : 0;
    m_cnt = (m_state == S_IDLE || m_state == S_CLR) ? 0 : m_cnt + 1;
    if (nxt == S_READ) m_addr = (m_state == S_READ) ? m_addr + int'(s) : 0;
    else if (nxt != S_DONE) m_addr = 0;
    m_pstp  = (nxt != m_state) ? 0 : m_pstp + int'(s);
    m_pulse = pulse;
    m_state = nxt;
  endtask

  function automatic logic [13:0] dut_vec();
    return {clk_rst, reset1, reset2, reset3, reset4, reset_reg, reset_counter_final,
            en_s, en_k, enc, wr_1, rd_1, busy, done};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [13:0] ev;
    ev = exp_tab[m_state];
    if (m_pulse) ev[12] = 1'b1;
    check($sformatf("cycle_st%0d", m_state), {10'd0, dut_vec(), add_to_read, state_o},
          {10'd0, ev, 4'(m_addr), 4'(m_state)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Nominal flags end each phase at step 8/16/16/21; glitch mode adds random flag
  // activity on cycles that are not steps.
  task automatic drive_flags(input bit glitch);
    bit s;
    int tgt;
    bit hit;
    s = m_stp();
    case (m_state)
      S_LOADS:        tgt = 8;
      S_LOADK, S_KSA: tgt = 16;
      S_PRGA:         tgt = 21;
      default:        tgt = 0;
    endcase
    hit  = s && (tgt != 0) && (m_pstp == tgt - 1);
    eqz3 = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
    eqz4 = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
    eqz5 = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
    if (s) begin
      case (m_state)
        S_LOADS:        eqz3 = hit;
        S_LOADK, S_KSA: eqz4 = hit;
        S_PRGA:         eqz5 = hit;
        default: ;
      endcase
    end
  endtask

  task automatic run_nominal(input bit glitch, input bit abort_ksa);
    int len [9];
    int done_cnt, rd_idx;
    bit fin, aborted;
    for (int s = 0; s < 9; s++) len[s] = 0;
    done_cnt = 0; rd_idx = 0; fin = 0; aborted = 0;
    start = 1'b1;
    abort = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      drive_flags(glitch);
      if (abort_ksa && m_state == S_KSA && m_pstp == 3) begin
        abort = 1'b1;
        aborted = 1;
      end
      tick();
      start = glitch;
      if (aborted) begin
        check("abort_to_idle", 32'(state_o), 32'(S_IDLE));
        abort = 1'b0;
        fin = 1;
      end else begin
        if (int'(state_o) < 9) len[int'(state_o)]++;
        if (state_o == 4'd7) begin
          check("read_addr", 32'(add_to_read), 32'(rd_idx / SD));
          rd_idx++;
        end
        if (done) done_cnt++;
        if (state_o == 4'd8) fin = 1;
      end
    end
    check("run_finished", 32'(fin), 32'd1);
    if (!abort_ksa) begin
      for (int s = 1; s < 9; s++)
        check($sformatf("phase_len_s%0d", s), 32'(len[s]), 32'(exp_len[s]));
      check("done_pulses", 32'(done_cnt), 32'd1);
      check("read_cycles", 32'(rd_idx), 32'(RW * SD));
    end
    start = 1'b0; eqz3 = 1'b0; eqz4 = 1'b0; eqz5 = 1'b0;
    tick();
    check("back_to_idle", 32'(state_o), 32'(S_IDLE));
  endtask

  task automatic run_until(input int target);
    start = 1'b1;
    abort = 1'b0;
    for (int c = 0; c < 400 && m_state != target; c++) begin
      drive_flags(1'b0);
      tick();
      start = 1'b0;
    end
    check("reach_state", 32'(state_o), 32'(target));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_tab[S_IDLE]  = 14'b11111110000000;
    exp_tab[S_CLR]   = 14'b11111110000010;
    exp_tab[S_LOADS] = 14'b00011111000010;
    exp_tab[S_LOADK] = 14'b00011110100010;
    exp_tab[S_KSA]   = 14'b00001110000010;
    exp_tab[S_PCLR]  = 14'b01000110000010;
    exp_tab[S_PRGA]  = 14'b00000000011010;
    exp_tab[S_READ]  = 14'b00000000000110;
    exp_tab[S_DONE]  = 14'b00000000000101;
    exp_len = '{0, 2, 16, 32, 32, 1, 41, 16, 1};

    iv[0] = '{0, 0, S_IDLE,  0};
    iv[1] = '{1, 1, S_IDLE,  0};
    iv[2] = '{0, 1, S_IDLE,  0};
    iv[3] = '{1, 0, S_CLR,   1};
    iv[4] = '{1, 0, S_CLR,   1};
    iv[5] = '{0, 0, S_LOADS, 1};
    iv[6] = '{1, 0, S_LOADS, 1};
    iv[7] = '{0, 1, S_IDLE,  0};
    iv[8] = '{0, 0, S_IDLE,  0};

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    eqz3 = 1'b0; eqz4 = 1'b0; eqz5 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_vec", 32'(dut_vec()), 32'(exp_tab[S_IDLE]));
    check("reset_addr_state", {24'd0, add_to_read, state_o}, 32'd0);
    reset = 1'b1;
    repeat (20) tick();

    for (int i = 0; i < 9; i++) begin
      start = iv[i].start;
      abort = iv[i].abort;
      tick();
      check($sformatf("idle_vec%0d_state", i), 32'(state_o), 32'(iv[i].exp_state));
      check($sformatf("idle_vec%0d_busy", i), 32'(busy), 32'(iv[i].exp_busy));
    end
    start = 1'b0;
    abort = 1'b0;

    run_nominal(1'b0, 1'b0);
    run_nominal(1'b0, 1'b1);
    run_nominal(1'b0, 1'b0);
    run_nominal(1'b1, 1'b0);

    run_until(S_PRGA);
    repeat (3) begin drive_flags(1'b0); tick(); end
    #2 reset = 1'b0;
    #1;
    check("async_rst_vec", 32'(dut_vec()), 32'(exp_tab[S_IDLE]));
    check("async_rst_addr_state", {24'd0, add_to_read, state_o}, 32'd0);
    model_reset();
    start = 1'b0; eqz3 = 1'b0; eqz4 = 1'b0; eqz5 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 79) == 0);
      eqz3  = ($urandom_range(0, 2) == 0);
      eqz4  = ($urandom_range(0, 2) == 0);
      eqz5  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
